// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared state encoding, limits and half-period helper for the divider
package freq_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int MIN_DIV = 2;
  function automatic int unsigned half_of(input int unsigned n);
    return (n + 1) >> 1;
  endfunction
endpackage

// File: rtl/freq_div_ctrl_if.sv
// freq_div_ctrl_if: ratio configuration handshake
interface freq_div_ctrl_if #(parameter int CW = 16);
    logic          cfg_valid;
    logic [CW-1:0] cfg_div;
    logic          cfg_ready;
    logic          cfg_err;
    modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
    modport slave (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/freq_div_core.sv
// freq_div_core: period counter with registered div_clk / div_tick
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          go,
    input  logic [CW-1:0] n,
    input  logic [CW-1:0] n_nxt,
    output logic          wrap,
    output logic          div_clk,
    output logic          div_tick
);
    logic [CW-1:0] count, cnt_nxt;
    always_comb begin
        wrap    = run && count == n - 1'b1;
        cnt_nxt = (!go || !run || wrap) ? '0 : count + 1'b1;
    end
    // outputs are registered from the next count so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            count    <= cnt_nxt;
            div_clk  <= go && cnt_nxt < CW'(half_of(32'(n_nxt)));
            div_tick <= go && cnt_nxt == '0;
        end
    end
endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: run/stop sequencing and boundary-aligned ratio updates for the divider
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int CW      = 16,
    parameter int DEF_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    freq_div_ctrl_if.slave   cfg,
    output logic             div_clk,
    output logic             div_tick,
    output logic             busy
);
    state_t        state, state_nxt;
    logic [CW-1:0] n, n_nxt, pend;
    logic          pend_v, run, go, wrap, acc, bad, direct, apply, ld_pend;
    freq_div_core #(.CW(CW)) u_core (
        .clk(clk), .rst(rst), .run(run), .go(go), .n(n), .n_nxt(n_nxt),
        .wrap(wrap), .div_clk(div_clk), .div_tick(div_tick)
    );
    // an idle, un-enabled divider is always at a period boundary
    always_comb begin
        run       = state != IDLE;
        state_nxt = en ? RUN : (run && !wrap) ? DRAIN : IDLE;
        go        = state_nxt != IDLE;
        acc       = cfg.cfg_valid && !pend_v;
        bad       = cfg.cfg_div < CW'(MIN_DIV);
        direct    = !run && !en;
        apply     = pend_v && (wrap || direct);
        ld_pend   = acc && !bad && !direct;
        n_nxt     = apply ? pend : (acc && !bad && direct) ? cfg.cfg_div : n;
    end
    assign busy          = run;
    assign cfg.cfg_ready = !pend_v;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            n           <= CW'(DEF_DIV);
            pend        <= '0;
            pend_v      <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            n           <= n_nxt;
            pend_v      <= apply ? 1'b0 : ld_pend ? 1'b1 : pend_v;
            if (ld_pend) pend <= cfg.cfg_div;
            cfg.cfg_err <= acc && bad;
        end
    end
endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
Run-time controller for an integer clock-enable divider.
- Holds the active divide ratio and accepts new ratios over a valid/ready handshake.
- Applies a new ratio only at a period boundary, so no truncated or stretched periods.
- Sequences start/stop cleanly: a stop always completes the current period.
- Single-edge design; downstream logic uses div_tick as a clock enable and div_clk as a visible reference.

Parameters:
CW, 16, width of ratio and counter
DEF_DIV, 5, active ratio after reset (must be >= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  run request, level-sensitive
cfg_valid  in  1  new ratio offered
cfg_div  in  CW  requested ratio N
cfg_ready  out  1  controller can accept a ratio
cfg_err  out  1  one-cycle pulse: offered ratio rejected
div_clk  out  1  divided clock, registered
div_tick  out  1  one-cycle pulse on the first cycle of each period
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, active N=DEF_DIV, pending slot empty.
  - div_clk=0, div_tick=0, cfg_err=0, cfg_ready=1.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when en=1; the first RUN cycle has count=0, div_clk=1, div_tick=1.
  - RUN -> DRAIN when en=0 and count != N-1.
  - RUN -> IDLE when en=0 and count == N-1.
  - DRAIN -> RUN when en=1, with no break in the period sequence.
  - DRAIN -> IDLE at wrap (count == N-1).
- Counter: count runs 0..N-1, then wraps to 0.
  - H = (N+1)>>1.
  - div_clk = (count < H), registered alongside count: high H cycles, low N-H cycles.
  - N=5 gives 3 high/2 low; N=4 gives 2/2.
  - div_tick = 1 exactly when count == 0 in RUN or DRAIN.
- IDLE outputs: div_clk=0, div_tick=0, count held at 0.
- Config handshake:
  - cfg_ready = pending slot empty.
  - Transfer when cfg_valid && cfg_ready.
  - cfg_div < 2: no transfer to the pending slot. Pulse cfg_err one cycle later; active N unchanged; cfg_ready stays 1.
  - Valid ratio in IDLE: becomes active N on the next cycle; slot stays empty.
  - Valid ratio in RUN or DRAIN: stored in the pending slot; cfg_ready=0 until it is applied.
  - Pending is applied on the wrap cycle, so the first count=0 after wrap uses the new N.
- Simultaneous events:
  - Accept coinciding with a wrap: the ratio goes to pending and applies at the next wrap, not the current one.
  - Wrap on which state goes to IDLE: pending is still applied; slot empties.
  - en and cfg_valid rising together in IDLE: the new ratio applies from the second period.
- Arithmetic:
  - All comparisons are unsigned, CW bits.
  - N = 2^CW-1 is legal.
  - Counter never exceeds N-1, even if N changes; changes happen only at wrap.
- Reset mid-period: outputs drop asynchronously and the pending ratio is discarded.

Decomposition:
- Shared package freq_div_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - MIN_DIV=2;
  - helper for H=(N+1)>>1.
- One natural sub-module: freq_div_core (counter + div_clk/div_tick generation, inputs N and run). freq_div_ctrl owns the FSM and config slot.

Test Plan:
- Reset release, en=1, DEF_DIV=5 -> div_tick every 5 cycles; div_clk pattern 1,1,1,0,0 repeating; busy=1.
- In RUN at N=5, write cfg_div=4 at count=1 -> cfg_ready=0 until wrap; next period 1,1,0,0; then cfg_ready=1.
- cfg_div=1 and cfg_div=0 offered -> cfg_err pulses once each; ratio stays 5; cfg_ready never drops.
- en=0 at count=2 with N=5 -> DRAIN for counts 3,4, then IDLE; div_clk=0, busy=0; no extra div_tick.
- en=0 at count=2, then en=1 at count=3 -> seamless continuation; tick spacing stays exactly 5.
- rst asserted at count=3 with a pending ratio -> outputs 0 immediately; after release and en=1, period=DEF_DIV.
